charlie_scan: RTL and testbench
===============================

// Module: charlie_scan
// PURPOSE
//  Parametrised charlieplexed LED matrix scanner with per-pixel PWM brightness. It drives
//  PINS tri-state pins (PINS*(PINS-1) LEDs) through SB_IO-style {oe,o} vectors. It sits
//  between the bus-side framebuffer writer and the board pad cells, and generalises the
//  fixed 7-pin on/off display driver to any pin count and brightness depth.
// PARAMETERS
//  PINS           7    charlieplex pin count, 3..16
//  BITS           4    brightness bits per pixel; level 0 = off, 2^BITS-1 = always on
//  TICKS_PER_STEP 64   clk cycles per PWM step, >=1
//  BLANK_TICKS    4    all-off cycles between rows, >=1; used only with CHARLIE_BLANK_EN
// PORTS
//  clk       in   1             system clock
//  rst_n     in   1             asynchronous active-low reset
//  enable    in   1             1 = scan; 0 = pins released at next row boundary
//  wr_en     in   1             framebuffer write strobe, single cycle, always accepted
//  wr_addr   in   AW            AW=$clog2(PINS*PINS); pixel = row*PINS+col, row=anode pin
//  wr_data   in   BITS          brightness level
//  pin_o     out  PINS          pad output value
//  pin_oe    out  PINS          pad output enable; 0 = hi-Z
//  frame_stb out  1             one-cycle pulse when row 0 is loaded
// BEHAVIOUR
//  - Reset: pin_o=0, pin_oe=0, frame_stb=0, row=0, pwm=0, prescaler=0, state IDLE, fb all 0.
//  - Framebuffer: PINS*PINS regs of BITS. Write lands on the clk edge with wr_en=1.
//    Dropped when col==row or wr_addr>=PINS*PINS.
//  - Prescaler counts 0..TICKS_PER_STEP-1; step tick when it is at max. Runs only in DRIVE.
//  - FSM:
//    IDLE : outputs released; enable=1 -> LOAD.
//    LOAD : 1 cycle. Copy fb row[row] into shadow; pwm=0; frame_stb=(row==0) -> DRIVE.
//    DRIVE: pin_oe[row]=1, pin_o[row]=1. For col!=row: pin_oe[col]=(shadow[col]>pwm), pin_o[col]=0.
//           On step tick pwm++. When pwm==2^BITS-2 on a tick: row=(row==PINS-1)?0:row+1 -> NEXT.
//    NEXT : if !enable -> IDLE (pins released same cycle), else -> LOAD (or BLANK, see below).
//  - Outputs are registered: pin values change one cycle after the state/pwm change.
//  - Row period = 1 + (2^BITS-1)*TICKS_PER_STEP + 1 clk (plus blank time if enabled).
//  - A write to the row being driven does not change its output until that row is next loaded.
//    No tearing within a row.
//  - Only one pin is driven high at any time; never two anodes. The anode pin never has oe
//    from the cathode path.
//  - enable dropped mid-row: current row completes, then IDLE. Re-enable resumes at stored row.
//  - rst_n low mid-scan: all pins hi-Z immediately (async). fb contents lost.
// CONFIGURATION
//  CHARLIE_BLANK_EN defined: NEXT -> BLANK; pin_oe=0 for BLANK_TICKS cycles -> LOAD.
//    This suppresses ghosting from pad/LED capacitance.
//  Undefined: no BLANK state; NEXT -> LOAD directly; BLANK_TICKS ignored.
// STRUCTURE
//  charlie_pkg: state encodings (IDLE, LOAD, DRIVE, NEXT, BLANK), AW helper function,
//    max-pwm constant.
//  Sub-module charlie_tick: prescaler with run input and one-cycle tick output. Reused by
//    other timed peripherals. Everything else stays in charlie_scan.
// TESTING
//  1 Reset asserted mid-DRIVE -> pin_oe=0, pin_o=0 asynchronously; frame_stb=0.
//  2 PINS=3, BITS=2, TPS=2: write addr1=3, enable -> pin_oe=3'b011, pin_o=3'b001 for all
//    6 DRIVE cycles of row 0.
//  3 Same config, level 1 at addr2 -> pin_oe[2]=1 for 2 of 6 row-0 DRIVE cycles; level 0 ->
//    never asserted.
//  4 Write addr0 (col==row) or addr 9 -> fb unchanged. Full-frame readback via pin monitor
//    matches the model.
//  5 frame_stb pulses once per PINS rows. Period = PINS*(2+3*TPS) clk (+BLANK_TICKS*PINS with
//    macro). Checker asserts popcount(pin_o&pin_oe)<=1 every cycle.
//  6 enable=0 mid-row 1 -> row 1 completes, then all pins hi-Z; re-enable -> next LOAD is row 2.

Source files
------------

// File: rtl/charlie_pkg.sv
// charlie_pkg: shared types and helpers for the charlieplexed LED scanner.
// Scan FSM state encodings, address-width helper and PWM ceiling helper.
package charlie_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRIVE = 3'd2,
    ST_NEXT  = 3'd3,
    ST_BLANK = 3'd4
  } state_e;

  // Framebuffer address width: one entry per (anode, cathode) pair.
  function automatic int charlie_aw(input int pins);
    return $clog2(pins * pins);
  endfunction

  // Last PWM step value in a row; level 2^bits-1 stays on through it.
  function automatic int charlie_max_pwm(input int bits);
    return (1 << bits) - 2;
  endfunction

endpackage

// File: rtl/charlie_tick.sv
// charlie_tick: free-running prescaler with a run gate.
// Counts 0..TICKS-1 while run=1 and raises tick on the terminal count.
// Dropping run clears the count, so every run window starts from zero.
module charlie_tick #(
  parameter int TICKS = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and terminal-count tick.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/charlie_scan.sv
// charlie_scan: charlieplexed LED matrix scanner with per-pixel PWM.
// One row (anode pin) at a time is driven high; cathodes sink when the
// latched brightness of their pixel exceeds the current PWM step.
// Optional macro CHARLIE_BLANK_EN inserts BLANK_TICKS all-off cycles
// between rows to suppress ghosting from pad/LED capacitance.
module charlie_scan
  import charlie_pkg::*;
#(
  parameter  int PINS           = 7,
  parameter  int BITS           = 4,
  parameter  int TICKS_PER_STEP = 64,
  parameter  int BLANK_TICKS    = 4,
  localparam int AW             = charlie_aw(PINS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  output logic [PINS-1:0] pin_o,
  output logic [PINS-1:0] pin_oe,
  output logic            frame_stb
);

  localparam int NPIX = PINS * PINS;
  localparam int RW   = $clog2(PINS);
  localparam logic [RW-1:0]   ROW_LAST = RW'(PINS - 1);
  localparam logic [BITS-1:0] PWM_LAST = BITS'(charlie_max_pwm(BITS));

  if (PINS < 3 || PINS > 16 || BITS < 1 || TICKS_PER_STEP < 1 || BLANK_TICKS < 1) begin : g_bad_param
    $error("charlie_scan: parameter out of range");
  end

  state_e                     state_q, state_d;
  logic [RW-1:0]              row_q, row_d;
  logic [BITS-1:0]            pwm_q, pwm_d;
  logic [PINS-1:0][BITS-1:0]  shadow_q, shadow_d;
  logic [BITS-1:0]            fb_q [NPIX];
  logic [BITS-1:0]            fb_d [NPIX];
  logic [PINS-1:0]            pin_o_q, pin_o_d;
  logic [PINS-1:0]            pin_oe_q, pin_oe_d;
  logic                       frame_stb_q, frame_stb_d;
  logic                       wr_ok;
  logic                       tick_run;
  logic                       step_tick;

`ifdef CHARLIE_BLANK_EN
  localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_TICKS - 1);
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
`endif

  // PWM step prescaler, counting only while a row is being driven.
  assign tick_run = (state_q == ST_DRIVE);

  charlie_tick #(
    .TICKS (TICKS_PER_STEP)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (tick_run),
    .tick  (step_tick)
  );

  // Write qualification: drop out-of-range addresses and diagonal
  // (anode == cathode) pixels, which have no physical LED.
  always_comb begin
    wr_ok = wr_en && (int'(wr_addr) < NPIX);
    for (int r = 0; r < PINS; r++) begin
      if (int'(wr_addr) == r * (PINS + 1)) wr_ok = 1'b0;
    end
  end

  // Framebuffer next state.
  always_comb begin
    fb_d = fb_q;
    if (wr_ok) fb_d[wr_addr] = wr_data;
  end

  // Scan FSM: row sequencing, shadow capture and PWM stepping.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    pwm_d    = pwm_q;
    shadow_d = shadow_q;
`ifdef CHARLIE_BLANK_EN
    blank_cnt_d = blank_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Latch the whole row so writes cannot tear the row in flight.
        for (int c = 0; c < PINS; c++) begin
          shadow_d[c] = fb_q[AW'(int'(row_q) * PINS + c)];
        end
        pwm_d   = '0;
        state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (step_tick) begin
          if (pwm_q == PWM_LAST) begin
            pwm_d   = '0;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            state_d = ST_NEXT;
          end else begin
            pwm_d = pwm_q + 1'b1;
          end
        end
      end
      ST_NEXT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
`ifdef CHARLIE_BLANK_EN
          blank_cnt_d = '0;
          state_d     = ST_BLANK;
`else
          state_d = ST_LOAD;
`endif
        end
      end
`ifdef CHARLIE_BLANK_EN
      ST_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) state_d = ST_LOAD;
        else                           blank_cnt_d = blank_cnt_q + 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad and strobe values, registered one cycle behind state/pwm.
  always_comb begin
    pin_o_d     = '0;
    pin_oe_d    = '0;
    frame_stb_d = (state_q == ST_LOAD) && (row_q == '0);
    if (state_q == ST_DRIVE) begin
      for (int c = 0; c < PINS; c++) begin
        if (RW'(c) == row_q) begin
          // Anode: the only pin ever driven high.
          pin_oe_d[c] = 1'b1;
          pin_o_d[c]  = 1'b1;
        end else begin
          pin_oe_d[c] = (shadow_q[c] > pwm_q);
        end
      end
    end
  end

  // State, datapath and framebuffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      pwm_q       <= '0;
      shadow_q    <= '0;
      fb_q        <= '{default: '0};
      pin_o_q     <= '0;
      pin_oe_q    <= '0;
      frame_stb_q <= 1'b0;
`ifdef CHARLIE_BLANK_EN
      blank_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      pwm_q       <= pwm_d;
      shadow_q    <= shadow_d;
      fb_q        <= fb_d;
      pin_o_q     <= pin_o_d;
      pin_oe_q    <= pin_oe_d;
      frame_stb_q <= frame_stb_d;
`ifdef CHARLIE_BLANK_EN
      blank_cnt_q <= blank_cnt_d;
`endif
    end
  end

  assign pin_o     = pin_o_q;
  assign pin_oe    = pin_oe_q;
  assign frame_stb = frame_stb_q;

endmodule

// File: tb/tb_charlie_scan.sv
// tb_charlie_scan: scoreboard bench for charlie_scan (PINS=3, BITS=2, TPS=2).
// Expected pad vectors for each driven cycle are queued when a row is
// scheduled and compared by a monitor whenever any pin is enabled.
module tb_charlie_scan;

  localparam int P     = 3;
  localparam int B     = 2;
  localparam int TPS   = 2;
  localparam int BT    = 4;
  localparam int STEPS = (1 << B) - 1;
`ifdef CHARLIE_BLANK_EN
  localparam int ROWP  = 2 + STEPS * TPS + BT;
`else
  localparam int ROWP  = 2 + STEPS * TPS;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [B-1:0] wr_data = '0;
  logic [P-1:0] pin_o, pin_oe;
  logic         frame_stb;

  typedef struct packed {
    logic [P-1:0] oe;
    logic [P-1:0] o;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  int   fb_m[P*P];
  int   model_row = 0;

  charlie_scan #(
    .PINS           (P),
    .BITS           (B),
    .TICKS_PER_STEP (TPS),
    .BLANK_TICKS    (BT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pin_o     (pin_o),
    .pin_oe    (pin_oe),
    .frame_stb (frame_stb)
  );

  always #5 clk = ~clk;

  // Monitor: single-anode invariant every cycle, scoreboard on driven cycles.
  always @(posedge clk) begin
    #1;
    if (mon_en && rst_n) begin
      checks++;
      if ($countones(pin_o & pin_oe) > 1)
        $display("FAIL one_anode o&oe=%b required at most one bit set", pin_o & pin_oe);
      else passes++;
      if (pin_oe != '0) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL stray_drive oe=%b o=%b required hi-Z", pin_oe, pin_o);
        end else begin
          mon_e = sb.pop_front();
          if (pin_oe !== mon_e.oe || pin_o !== mon_e.o)
            $display("FAIL pins oe=%b o=%b required oe=%b o=%b", pin_oe, pin_o, mon_e.oe, mon_e.o);
          else passes++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    mon_en = 1'b0;
    enable = 1'b0;
    wr_en  = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    for (int i = 0; i < P*P; i++) fb_m[i] = 0;
    model_row = 0;
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = B'(d);
    @(negedge clk);
    wr_en = 1'b0;
    if (a < P*P && (a % P) != (a / P)) fb_m[a] = d;
  endtask

  // Reference: anode high; cathode c sinks while its level exceeds the step.
  task automatic push_row(input int r);
    exp_t e;
    for (int s = 0; s < STEPS; s++) begin
      for (int t = 0; t < TPS; t++) begin
        e.o  = '0;
        e.oe = '0;
        e.o[r]  = 1'b1;
        e.oe[r] = 1'b1;
        for (int c = 0; c < P; c++)
          if (c != r && fb_m[r*P + c] > s) e.oe[c] = 1'b1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic sched_rows(input int n);
    for (int i = 0; i < n; i++) begin
      push_row(model_row);
      model_row = (model_row + 1) % P;
    end
  endtask

  task automatic wait_drain(input int nrows);
    int i = 0;
    while (sb.size() != 0 && i < nrows * ROWP + 40) begin
      @(negedge clk);
      i++;
    end
    enable = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL drain_timeout left=%0d required=0", sb.size());
      sb.delete();
    end else passes++;
    repeat (ROWP + 4) @(negedge clk);
  endtask

  task automatic run_rows(input int n);
    sched_rows(n);
    @(negedge clk);
    enable = 1'b1;
    wait_drain(n);
  endtask

  task automatic test_reset();
    int i = 0;
    rst_n = 1'b0;
    @(negedge clk);
    checks += 3;
    if (pin_oe !== '0) $display("FAIL reset_oe got=%b required=000", pin_oe); else passes++;
    if (pin_o !== '0) $display("FAIL reset_o got=%b required=000", pin_o); else passes++;
    if (frame_stb !== 1'b0) $display("FAIL reset_stb got=%b required=0", frame_stb); else passes++;
    // Assert reset asynchronously while a row is being driven.
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    while (pin_oe == '0 && i < 4 * ROWP) begin @(negedge clk); i++; end
    checks++;
    if (pin_oe == '0) $display("FAIL reset_predrive oe=%b required nonzero", pin_oe); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (pin_oe !== '0) $display("FAIL async_oe got=%b required=000", pin_oe); else passes++;
    if (pin_o !== '0) $display("FAIL async_o got=%b required=000", pin_o); else passes++;
    if (frame_stb !== 1'b0) $display("FAIL async_stb got=%b required=0", frame_stb); else passes++;
    do_reset();
  endtask

  task automatic test_drive();
    do_reset();
    wr(1, 3);
    sched_rows(1);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    checks += 2;
    if (frame_stb !== 1'b0) $display("FAIL drive_stb_early got=%b required=0", frame_stb); else passes++;
    if (pin_oe !== '0) $display("FAIL drive_early oe=%b required=000", pin_oe); else passes++;
    @(negedge clk);
    checks++;
    if (frame_stb !== 1'b1) $display("FAIL drive_stb got=%b required=1", frame_stb); else passes++;
    @(negedge clk);
    checks += 2;
    if (pin_oe !== 3'b011) $display("FAIL drive_first_oe got=%b required=011", pin_oe); else passes++;
    if (pin_o !== 3'b001) $display("FAIL drive_first_o got=%b required=001", pin_o); else passes++;
    wait_drain(1);
    run_rows(2);
    run_rows(P);
  endtask

  task automatic test_levels();
    int i = 0;
    int row0 = 0;
    int on1 = 0;
    int on2 = 0;
    do_reset();
    wr(1, 0);
    wr(2, 1);
    wr(3, 2);
    sched_rows(1);
    @(negedge clk);
    enable = 1'b1;
    while (sb.size() != 0 && i < 2 * ROWP) begin
      @(negedge clk);
      i++;
      if (pin_oe[0] && pin_o[0]) begin
        row0++;
        if (pin_oe[1]) on1++;
        if (pin_oe[2]) on2++;
      end
    end
    enable = 1'b0;
    checks += 3;
    if (row0 != STEPS * TPS) $display("FAIL level_row_len got=%0d required=%0d", row0, STEPS * TPS); else passes++;
    if (on2 != TPS) $display("FAIL level1_cycles got=%0d required=%0d", on2, TPS); else passes++;
    if (on1 != 0) $display("FAIL level0_cycles got=%0d required=0", on1); else passes++;
    wait_drain(1);
    run_rows(2);
  endtask

  task automatic test_write_filter();
    do_reset();
    for (int a = 0; a < P*P; a++) wr(a, $urandom_range(0, STEPS));
    wr(0, 3);
    wr(4, 3);
    wr(8, 3);
    wr(9, 3);
    wr(15, 2);
    run_rows(P);
    wr(5, 2);
    wr(6, 1);
    run_rows(P);
  endtask

  task automatic test_frame();
    int i = 0;
    int n = 0;
    int highs = 0;
    int t[3];
    bit prev = 1'b0;
    do_reset();
    wr(1, 2);
    wr(5, 1);
    wr(7, 3);
    sched_rows(3 * P);
    @(negedge clk);
    enable = 1'b1;
    while (sb.size() != 0 && i < 3 * P * ROWP + 40) begin
      @(negedge clk);
      i++;
      if (frame_stb) begin
        highs++;
        if (!prev && n < 3) begin t[n] = i; n++; end
      end
      prev = frame_stb;
    end
    enable = 1'b0;
    checks += 2;
    if (n != 3) $display("FAIL frame_pulses got=%0d required=3", n); else passes++;
    if (highs != 3) $display("FAIL frame_width got=%0d required=3", highs); else passes++;
    if (n == 3) begin
      checks += 2;
      if (t[1] - t[0] != P * ROWP) $display("FAIL frame_period0 got=%0d required=%0d", t[1] - t[0], P * ROWP); else passes++;
      if (t[2] - t[1] != P * ROWP) $display("FAIL frame_period1 got=%0d required=%0d", t[2] - t[1], P * ROWP); else passes++;
    end
    wait_drain(1);
  endtask

  task automatic test_enable_drop();
    int i = 0;
    do_reset();
    wr(1, 1);
    wr(3, 3);
    wr(5, 2);
    wr(6, 2);
    sched_rows(2);
    @(negedge clk);
    enable = 1'b1;
    while (!(pin_oe[1] && pin_o[1]) && i < 3 * ROWP) begin @(negedge clk); i++; end
    enable = 1'b0;
    checks++;
    if (pin_o !== 3'b010) $display("FAIL drop_row1 o=%b required=010", pin_o); else passes++;
    wait_drain(2);
    repeat (ROWP) @(negedge clk);
    checks++;
    if (pin_oe !== '0) $display("FAIL drop_hiz oe=%b required=000", pin_oe); else passes++;
    sched_rows(2);
    @(negedge clk);
    enable = 1'b1;
    i = 0;
    while (pin_oe == '0 && i < 2 * ROWP) begin @(negedge clk); i++; end
    checks++;
    if (pin_o !== 3'b100) $display("FAIL resume_row o=%b required=100", pin_o); else passes++;
    wait_drain(2);
  endtask

  task automatic test_back_to_back();
    int i = 0;
    do_reset();
    wr(1, 1);
    wr(2, 0);
    sched_rows(1);
    @(negedge clk);
    enable = 1'b1;
    while (pin_oe == '0 && i < 2 * ROWP) begin @(negedge clk); i++; end
    // Rewrite row 0 while it is on the pads; it must not change until reloaded.
    wr(1, 3);
    wr(2, 2);
    wr(7, 1);
    sched_rows(P);
    wait_drain(P + 1);
  endtask

  initial begin
    test_reset();
    test_drive();
    test_levels();
    test_write_filter();
    test_frame();
    test_enable_drop();
    test_back_to_back();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
